// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the SRAM-like arbiter: transfer sizes, owner tags and grant FSM states.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } arb_state_e;

  function automatic arb_state_e lock_state(input logic owner);
    return (owner == OWNER_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order owner tag FIFO: one bit per accepted request, popped as responses return.
module sram_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like downstream port between fetch (inst) and EXE (data) requesters,
// with data priority, a starvation guard for fetch, and in-order response routing.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        out_req,
  output logic        out_wr,
  output logic [1:0]  out_size,
  output logic [31:0] out_addr,
  output logic [3:0]  out_wstrb,
  output logic [31:0] out_wdata,
  input  logic        out_addr_ok,
  input  logic        out_data_ok,
  input  logic [31:0] out_rdata,
  output logic        proto_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic          gnt_valid;
  logic          gnt_owner;
  logic          accept;
  logic          resp_valid;
  logic          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  // Fetch gets one forced grant once data has won STARVE_LIMIT times in a row over it.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = OWNER_INST;
    case (state)
      ST_IDLE: begin
        if (!fifo_full) begin
          if (data_req && !(inst_req && starve_cnt == SW'(STARVE_LIMIT))) begin
            gnt_valid = 1'b1;
            gnt_owner = OWNER_DATA;
          end else if (inst_req) begin
            gnt_valid = 1'b1;
            gnt_owner = OWNER_INST;
          end
        end
      end
      ST_LOCK_INST: begin
        gnt_valid = 1'b1;
        gnt_owner = OWNER_INST;
      end
      ST_LOCK_DATA: begin
        gnt_valid = 1'b1;
        gnt_owner = OWNER_DATA;
      end
      default: ;
    endcase
    if (!resetn) gnt_valid = 1'b0;
  end

  assign accept     = gnt_valid && out_addr_ok;
  assign resp_valid = resetn && out_data_ok && !fifo_empty;

  assign out_req   = gnt_valid;
  assign out_wr    = (gnt_owner == OWNER_DATA) ? data_wr    : inst_wr;
  assign out_size  = (gnt_owner == OWNER_DATA) ? data_size  : inst_size;
  assign out_addr  = (gnt_owner == OWNER_DATA) ? data_addr  : inst_addr;
  assign out_wstrb = (gnt_owner == OWNER_DATA) ? data_wstrb : inst_wstrb;
  assign out_wdata = (gnt_owner == OWNER_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = accept && (gnt_owner == OWNER_INST);
  assign data_addr_ok = accept && (gnt_owner == OWNER_DATA);
  assign inst_data_ok = resp_valid && (fifo_head == OWNER_INST);
  assign data_data_ok = resp_valid && (fifo_head == OWNER_DATA);
  assign inst_rdata   = out_rdata;
  assign data_rdata   = out_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:      if (gnt_valid && !out_addr_ok) state <= lock_state(gnt_owner);
        ST_LOCK_INST,
        ST_LOCK_DATA: if (out_addr_ok) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase

      if (!inst_req) starve_cnt <= '0;
      else if (accept && gnt_owner == OWNER_INST) starve_cnt <= '0;
      else if (accept && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);

      if (out_data_ok && fifo_empty) proto_err <= 1'b1;
    end
  end

  sram_owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (resp_valid),
    .din    (gnt_owner),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_sram_like_arbiter;
  localparam int OUTS  = 4;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        out_req, out_wr;
  logic [1:0]  out_size;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_wstrb;
  logic        out_addr_ok, out_data_ok;
  logic [31:0] out_rdata;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int q[$];
  int m_starve;
  int m_lock;
  bit m_proto;
  // Expectations for the current cycle
  bit e_req, e_own, e_iaok, e_daok, e_idok, e_ddok, e_resp;
  logic [31:0] e_addr, e_wdata;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING(OUTS), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_req(out_req), .out_wr(out_wr), .out_size(out_size), .out_addr(out_addr),
    .out_wstrb(out_wstrb), .out_wdata(out_wdata),
    .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok), .out_rdata(out_rdata),
    .proto_err(proto_err)
  );

  task automatic model_eval();
    e_req = 0;
    e_own = 0;
    if (resetn) begin
      if (m_lock >= 0) begin
        e_req = 1;
        e_own = (m_lock == 1);
      end else if (q.size() < OUTS) begin
        if (data_req && !(inst_req && m_starve == LIMIT)) begin
          e_req = 1; e_own = 1;
        end else if (inst_req) begin
          e_req = 1; e_own = 0;
        end
      end
    end
    e_iaok = e_req && out_addr_ok && !e_own;
    e_daok = e_req && out_addr_ok && e_own;
    e_resp = resetn && out_data_ok && q.size() > 0;
    e_idok = e_resp && q[0] == 0;
    e_ddok = e_resp && q[0] == 1;
    e_addr  = e_own ? data_addr : inst_addr;
    e_wdata = e_own ? data_wdata : inst_wdata;
  endtask

  task automatic model_commit();
    if (!resetn) begin
      q.delete();
      m_starve = 0;
      m_lock = -1;
      m_proto = 0;
    end else begin
      if (out_data_ok && q.size() == 0) m_proto = 1;
      if (e_resp) void'(q.pop_front());
      if (e_req && out_addr_ok) q.push_back(int'(e_own));
      m_lock = (e_req && !out_addr_ok) ? int'(e_own) : -1;
      if (!inst_req) m_starve = 0;
      else if (e_req && out_addr_ok) begin
        if (!e_own) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; out_addr_ok = 0; out_data_ok = 0;
    inst_addr  = 32'h1000_0000 | ($urandom & 32'hFFFC);
    data_addr  = 32'h8000_0000 | ($urandom & 32'hFFFC);
    inst_wdata = $urandom; data_wdata = $urandom; out_rdata = $urandom;
  endtask

  task automatic apply_reset();
    idle_inputs();
    resetn = 0;
    settle();
    advance();
    resetn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    inst_req = 1; data_req = 1; out_addr_ok = 1; out_data_ok = 1;
    resetn = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({out_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
        failures++;
        $display("FAIL reset_strobes got %b exp 00000",
                 {out_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
      end
      checks++;
      if (proto_err !== 1'b0) begin
        failures++; $display("FAIL reset_proto_err got %b exp 0", proto_err);
      end
      advance();
    end
    resetn = 1;
  endtask

  task automatic test_starvation();
    bit seq[6] = '{1, 1, 1, 1, 0, 1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      inst_req = 1; data_req = 1; out_addr_ok = 1;
      out_data_ok = (i > 0);
      out_rdata = $urandom;
      settle();
      checks++;
      if (data_addr_ok !== seq[i] || inst_addr_ok !== !seq[i]) begin
        failures++;
        $display("FAIL starve_grant cyc%0d got i=%b d=%b exp owner %0d", i, inst_addr_ok, data_addr_ok, seq[i]);
      end
      checks++;
      if (out_addr !== (seq[i] ? data_addr : inst_addr)) begin
        failures++; $display("FAIL starve_addr cyc%0d got %h", i, out_addr);
      end
      if (i > 0) begin
        checks++;
        if (inst_data_ok !== !seq[i-1] || data_data_ok !== seq[i-1]) begin
          failures++;
          $display("FAIL starve_route cyc%0d got i=%b d=%b exp owner %0d", i, inst_data_ok, data_data_ok, seq[i-1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      inst_req = (i <= 4);
      data_req = (i >= 2);
      out_addr_ok = (i >= 4);
      settle();
      if (i <= 4) begin
        checks++;
        if (out_req !== 1'b1 || out_addr !== inst_addr) begin
          failures++; $display("FAIL lock_addr cyc%0d got req=%b addr=%h exp %h", i, out_req, out_addr, inst_addr);
        end
      end
      checks++;
      if (inst_addr_ok !== (i == 4) || data_addr_ok !== (i == 5)) begin
        failures++; $display("FAIL lock_aok cyc%0d got i=%b d=%b", i, inst_addr_ok, data_addr_ok);
      end
      advance();
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      inst_req = 1; out_addr_ok = 1;
      out_data_ok = (i == 5);
      settle();
      checks++;
      if (out_req !== (i < 4 || i == 6) || inst_addr_ok !== e_iaok) begin
        failures++; $display("FAIL full_req cyc%0d got req=%b aok=%b exp req=%b", i, out_req, inst_addr_ok, (i < 4 || i == 6));
      end
      checks++;
      if (inst_data_ok !== (i == 5)) begin
        failures++; $display("FAIL full_dok cyc%0d got %b exp %b", i, inst_data_ok, (i == 5));
      end
      advance();
    end
  endtask

  task automatic test_wrap_routing();
    // issue: 0 inst, 1 data, 2 none; ret: owner expected to receive the response
    int issue[6] = '{0, 1, 1, 0, 2, 2};
    int ret[6]   = '{2, 2, 0, 1, 1, 0};
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        idle_inputs();
        inst_req = (issue[i] == 0); data_req = (issue[i] == 1); out_addr_ok = (issue[i] != 2);
        out_data_ok = (ret[i] != 2);
        out_rdata = 32'h1111_1111 * (i - 1);
        settle();
        checks++;
        if (inst_data_ok !== (ret[i] == 0) || data_data_ok !== (ret[i] == 1)) begin
          failures++; $display("FAIL wrap_route r%0d cyc%0d got i=%b d=%b exp %0d", r, i, inst_data_ok, data_data_ok, ret[i]);
        end
        if (ret[i] != 2) begin
          checks++;
          if ((ret[i] == 0 ? inst_rdata : data_rdata) !== 32'h1111_1111 * (i - 1)) begin
            failures++; $display("FAIL wrap_rdata r%0d cyc%0d got %h/%h exp %h", r, i, inst_rdata, data_rdata, 32'h1111_1111 * (i - 1));
          end
        end
        advance();
      end
    end
  endtask

  task automatic test_proto_err();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      out_data_ok = (i == 0);
      resetn = (i != 4);
      settle();
      checks++;
      if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
        failures++; $display("FAIL proto_strobe cyc%0d got i=%b d=%b exp 0", i, inst_data_ok, data_data_ok);
      end
      checks++;
      if (proto_err !== (i != 0)) begin
        failures++; $display("FAIL proto_sticky cyc%0d got %b exp %b", i, proto_err, (i != 0));
      end
      advance();
    end
    resetn = 1;
    idle_inputs();
    settle();
    checks++;
    if (proto_err !== 1'b0) begin
      failures++; $display("FAIL proto_clear got %b exp 0", proto_err);
    end
    advance();
  endtask

  task automatic test_reset_in_lock();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      resetn = (i != 3);
      inst_req = (i < 2 || i >= 4);
      data_req = (i == 2 || i == 3);
      out_addr_ok = (i < 2) || (i == 3);
      out_data_ok = (i == 3) || (i == 5);
      settle();
      if (i == 3) begin
        checks++;
        if ({out_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
          failures++; $display("FAIL rstlock_strobes got %b exp 00000",
                               {out_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
      end
      if (i == 4) begin
        checks++;
        if (out_req !== 1'b1 || out_addr !== inst_addr) begin
          failures++; $display("FAIL rstlock_idle got req=%b addr=%h exp %h", out_req, out_addr, inst_addr);
        end
      end
      if (i == 5) begin
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
          failures++; $display("FAIL rstlock_count got i=%b d=%b exp 0", inst_data_ok, data_data_ok);
        end
      end
      advance();
    end
    settle();
    checks++;
    if (proto_err !== 1'b1) begin
      failures++; $display("FAIL rstlock_proto got %b exp 1", proto_err);
    end
    advance();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      inst_req = ($urandom_range(0, 3) != 0);
      data_req = ($urandom_range(0, 2) != 0);
      inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
      data_wr = $urandom; data_size = $urandom_range(0, 2); data_wstrb = $urandom;
      out_addr_ok = ($urandom_range(0, 2) != 0);
      out_data_ok = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
      settle();
      checks++;
      if (out_req !== e_req || inst_addr_ok !== e_iaok || data_addr_ok !== e_daok) begin
        failures++; $display("FAIL rnd_grant cyc%0d got req=%b ia=%b da=%b exp %b %b %b",
                             i, out_req, inst_addr_ok, data_addr_ok, e_req, e_iaok, e_daok);
      end
      if (e_req) begin
        checks++;
        if (out_addr !== e_addr || out_wdata !== e_wdata ||
            out_wr !== (e_own ? data_wr : inst_wr) || out_wstrb !== (e_own ? data_wstrb : inst_wstrb)) begin
          failures++; $display("FAIL rnd_mux cyc%0d got addr=%h wdata=%h exp %h %h", i, out_addr, out_wdata, e_addr, e_wdata);
        end
      end
      checks++;
      if (inst_data_ok !== e_idok || data_data_ok !== e_ddok) begin
        failures++; $display("FAIL rnd_route cyc%0d got i=%b d=%b exp %b %b", i, inst_data_ok, data_data_ok, e_idok, e_ddok);
      end
      checks++;
      if (proto_err !== m_proto || inst_rdata !== out_rdata || data_rdata !== out_rdata) begin
        failures++; $display("FAIL rnd_misc cyc%0d got perr=%b exp %b", i, proto_err, m_proto);
      end
      advance();
    end
  endtask

  initial begin
    resetn = 0;
    inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
    data_wr = 0; data_size = 2'd2; data_wstrb = 4'hF;
    idle_inputs();
    q.delete(); m_starve = 0; m_lock = -1; m_proto = 0;
    @(negedge clk);
    test_reset();
    test_starvation();
    test_lock();
    test_full();
    test_wrap_routing();
    test_proto_err();
    test_reset_in_lock();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
